credit_sender_push: RTL and testbench

- Upstream neighbour of the credit-based CDC FIFO: sits in the push clock domain and drives that FIFO's push interface (valid, data, sender_in_reset), consuming its credit return.
- Converts an upstream ready/valid stream into credit-gated valid-only transfers. Holds the credit counter and runs the reset handshake with the receiver.
- Guarantees the FIFO is never pushed without a credit.

---
 rtl/credit_sender_push_if.sv | 28 ++
 rtl/credit_sender_push.sv | 134 +++++++++++++
 tb/tb_credit_sender_push.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/credit_sender_push_if.sv
// Credit link between the sender and its two neighbours.
// Upstream ready/valid stream: push_valid, push_ready, push_data.
// Downstream FIFO push side: out_valid, out_data, sender_in_reset,
// receiver_in_reset and credit_return.
// modport master: the credit sender.
// modport slave:  the environment (upstream source plus receiver).
interface credit_sender_push_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  sender_in_reset;
  logic                  receiver_in_reset;
  logic                  credit_return;

  modport master (
    input  push_valid, push_data, receiver_in_reset, credit_return,
    output push_ready, out_valid, out_data, sender_in_reset
  );

  modport slave (
    output push_valid, push_data, receiver_in_reset, credit_return,
    input  push_ready, out_valid, out_data, sender_in_reset
  );
endinterface

// File: rtl/credit_sender_push.sv
// Credit sender, push clock domain of a credit-based CDC FIFO.
// Turns an upstream ready/valid stream into credit-gated valid-only pushes,
// holds the credit counter and runs the reset handshake with the receiver.
// Ports:
//   push_clk, push_rst_n  clock, asynchronous active-low reset
//   bus (master)          upstream stream + downstream FIFO push/credit link
//   credit_stall          blocks new sends; credits still accepted
//   credit_initial        credits loaded while not active
//   credit_withhold       credits held back from use
//   credit_count          credits currently held (registered)
//   credit_available      credits usable this cycle (combinational)
//   credit_error          sticky protocol error
// Optional feature: define CREDIT_SENDER_ERR_CHECK_EN to enable credit_error;
// otherwise credit_error is tied 0.
module credit_sender_push #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_CREDIT   = 17,
  parameter int unsigned CREDIT_WIDTH = 5
) (
  input  logic                    push_clk,
  input  logic                    push_rst_n,
  credit_sender_push_if.master    bus,
  input  logic                    credit_stall,
  input  logic [CREDIT_WIDTH-1:0] credit_initial,
  input  logic [CREDIT_WIDTH-1:0] credit_withhold,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic [CREDIT_WIDTH-1:0] credit_available,
  output logic                    credit_error
);

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam logic [CREDIT_WIDTH-1:0] LP_MAX = CREDIT_WIDTH'(MAX_CREDIT);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_sender_in_reset;
  logic [CREDIT_WIDTH-1:0] r_count;
  logic [CREDIT_WIDTH-1:0] w_count_nxt;
  logic [CREDIT_WIDTH-1:0] w_avail;
  logic                    w_active;
  logic                    w_ready;
  logic                    w_send;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;

  // Reset handshake: RST until receiver enters reset, WAIT until it leaves.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RST:    if (bus.receiver_in_reset)  w_state_nxt = S_WAIT;
      S_WAIT:   if (!bus.receiver_in_reset) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (bus.receiver_in_reset)  w_state_nxt = S_RST;
      default:                              w_state_nxt = S_RST;
    endcase
  end

  // State register; sender_in_reset tracks the RST state exactly.
  always_ff @(posedge push_clk or negedge push_rst_n) begin
    if (!push_rst_n) begin
      r_state           <= S_RST;
      r_sender_in_reset <= 1'b1;
    end else begin
      r_state           <= w_state_nxt;
      r_sender_in_reset <= (w_state_nxt == S_RST);
    end
  end

  assign w_active = (r_state == S_ACTIVE);

  // Usable credits; a credit returned this cycle only counts next cycle.
  assign w_avail = (r_count > credit_withhold) ? (r_count - credit_withhold)
                                               : '0;

  // Receiver reset blocks sends in the same cycle it is seen.
  assign w_ready = w_active && !credit_stall && (w_avail != '0) &&
                   !bus.receiver_in_reset;
  assign w_send  = bus.push_valid && w_ready;

  // Credit update; send implies count >= 1, so no underflow path exists.
  always_comb begin
    w_count_nxt = r_count;
    if (!w_active) begin
      w_count_nxt = credit_initial;
    end else if (bus.credit_return && !w_send) begin
      if (r_count != LP_MAX) w_count_nxt = r_count + CREDIT_WIDTH'(1);
    end else if (w_send && !bus.credit_return) begin
      w_count_nxt = r_count - CREDIT_WIDTH'(1);
    end
  end

  // Credit counter and one-cycle output stage.
  always_ff @(posedge push_clk or negedge push_rst_n) begin
    if (!push_rst_n) begin
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_out_valid <= w_send;
      if (w_send) r_out_data <= bus.push_data;
    end
  end

`ifdef CREDIT_SENDER_ERR_CHECK_EN
  logic r_error;
  logic w_error_set;

  // Overflowing return while active, or an impossible initial credit load.
  assign w_error_set = (w_active && bus.credit_return && (r_count == LP_MAX)) ||
                       ((r_state == S_RST) && (credit_initial > LP_MAX));

  always_ff @(posedge push_clk or negedge push_rst_n) begin
    if (!push_rst_n) r_error <= 1'b0;
    else if (w_error_set) r_error <= 1'b1;
  end

  assign credit_error = r_error;
`else
  assign credit_error = 1'b0;
`endif

  assign bus.push_ready      = w_ready;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_data        = r_out_data;
  assign bus.sender_in_reset = r_sender_in_reset;
  assign credit_count        = r_count;
  assign credit_available    = w_avail;

endmodule

// File: tb/tb_credit_sender_push.sv
// Directed bench for credit_sender_push: reset handshake with a 2-cycle
// receiver model, table-driven credit/withhold/stall vectors, then
// hand-written receiver-reset and overflow sequences.
module tb_credit_sender_push;
  localparam int unsigned DW = 8;
  localparam int unsigned MC = 17;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic [CW-1:0] cinit;
  logic [CW-1:0] wh;
  logic [CW-1:0] cnt;
  logic [CW-1:0] avail;
  logic          err;

  logic [1:0]    rx_pipe;
  logic          rx_auto;
  logic          rx_force;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  credit_sender_push_if #(.DATA_WIDTH(DW)) bus ();

  // Receiver model: receiver_in_reset follows sender_in_reset by 2 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_pipe <= 2'b00;
    else        rx_pipe <= {rx_pipe[0], bus.sender_in_reset};
  end
  assign bus.receiver_in_reset = rx_auto ? rx_pipe[1] : rx_force;

  credit_sender_push #(
    .DATA_WIDTH  (DW),
    .MAX_CREDIT  (MC),
    .CREDIT_WIDTH(CW)
  ) dut (
    .push_clk        (clk),
    .push_rst_n      (rst_n),
    .bus             (bus),
    .credit_stall    (stall),
    .credit_initial  (cinit),
    .credit_withhold (wh),
    .credit_count    (cnt),
    .credit_available(avail),
    .credit_error    (err)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          ret;
    logic          st;
    logic [CW-1:0] wh;
    logic          e_rdy;
    logic [CW-1:0] e_av;
    logic [CW-1:0] e_cnt;
    logic          e_ov;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] last_od = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input int v, input int d, input int ret, input int st,
                     input int w, input int rdy, input int av, input int c,
                     input int ov);
    vec_t r;
    r.v     = 1'(v);
    r.d     = DW'(d);
    r.ret   = 1'(ret);
    r.st    = 1'(st);
    r.wh    = CW'(w);
    r.e_rdy = 1'(rdy);
    r.e_av  = CW'(av);
    r.e_cnt = CW'(c);
    r.e_ov  = 1'(ov);
    if (ov != 0) last_od = DW'(d);
    r.e_od  = last_od;
    vecs.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n_hi;
    bit  done;
    bit  saw_rst;
    bit  saw_drop;
    int  dval;

    rst_n     = 1'b0;
    rx_auto   = 1'b1;
    rx_force  = 1'b0;
    stall     = 1'b0;
    cinit     = CW'(17);
    wh        = '0;
    bus.push_valid    = 1'b0;
    bus.push_data     = '0;
    bus.credit_return = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_sender_in_reset", 32'(bus.sender_in_reset), 1);
    chk("rst_out_valid",       32'(bus.out_valid), 0);
    chk("rst_out_data",        32'(bus.out_data), 0);
    chk("rst_count",           32'(cnt), 0);
    chk("rst_available",       32'(avail), 0);
    chk("rst_ready",           32'(bus.push_ready), 0);
    chk("rst_error",           32'(err), 0);

    // ---- reset handshake ----
    rst_n = 1'b1;
    tick();
    chk("hs_load_initial", 32'(cnt), 17);
    n_hi = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.sender_in_reset) begin
        n_hi++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    chk("hs_sender_in_reset_post_release_cycles", n_hi, 2);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.push_ready) done = 1'b1;
      else begin
        chk("hs_wait_sender_in_reset", 32'(bus.sender_in_reset), 0);
        tick();
      end
    end
    chk("hs_active_reached", done ? 1 : 0, 1);
    chk("hs_count",     32'(cnt), 17);
    chk("hs_available", 32'(avail), 17);

    // ---- vector table ----
    for (int i = 0; i < 17; i++) add(1, i, 0, 0, 0, 1, 17 - i, 16 - i, 1);
    add(1, 'h11, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 17; j++) add(0, 'hAA, 1, 0, 0, (j != 0) ? 1 : 0, j, j + 1, 0);
    for (int m = 0; m < 12; m++) add(1, 'h20 + m, 0, 0, 5, 1, 12 - m, 16 - m, 1);
    add(1, 'h2C, 0, 0, 5, 0, 0, 5, 0);
    add(1, 'h2D, 1, 1, 5, 0, 0, 6, 0);
    add(1, 'h2E, 1, 1, 5, 0, 1, 7, 0);
    add(0, 'h00, 0, 1, 5, 0, 2, 7, 0);
    add(0, 'h00, 0, 0, 5, 1, 2, 7, 0);
    for (int k = 0; k < 4; k++) add(1, 'h40 + k, 0, 0, 0, 1, 7 - k, 6 - k, 1);
    add(1, 'h50, 1, 0, 0, 1, 3, 3, 1);
    add(0, 'h00, 0, 0, 0, 1, 3, 3, 0);

    for (int r = 0; r < vecs.size(); r++) begin
      bus.push_valid    = vecs[r].v;
      bus.push_data     = vecs[r].d;
      bus.credit_return = vecs[r].ret;
      stall             = vecs[r].st;
      wh                = vecs[r].wh;
      #1;
      chk($sformatf("vec%0d_ready", r), 32'(bus.push_ready), 32'(vecs[r].e_rdy));
      chk($sformatf("vec%0d_avail", r), 32'(avail), 32'(vecs[r].e_av));
      tick();
      chk($sformatf("vec%0d_count", r), 32'(cnt), 32'(vecs[r].e_cnt));
      chk($sformatf("vec%0d_out_valid", r), 32'(bus.out_valid), 32'(vecs[r].e_ov));
      chk($sformatf("vec%0d_out_data", r), 32'(bus.out_data), 32'(vecs[r].e_od));
    end

    // ---- receiver reset mid-burst ----
    bus.push_valid    = 1'b1;
    bus.push_data     = 8'h60;
    bus.credit_return = 1'b0;
    stall             = 1'b0;
    wh                = '0;
    #1;
    chk("mid_ready_before", 32'(bus.push_ready), 1);
    tick();
    chk("mid_out_valid_before", 32'(bus.out_valid), 1);
    chk("mid_out_data_before",  32'(bus.out_data), 'h60);
    chk("mid_count_before",     32'(cnt), 2);
    rx_auto       = 1'b0;
    rx_force      = 1'b1;
    cinit         = CW'(9);
    bus.push_data = 8'h61;
    #1;
    chk("mid_ready_drop", 32'(bus.push_ready), 0);
    tick();
    chk("mid_out_valid_drop", 32'(bus.out_valid), 0);
    chk("mid_sender_in_reset", 32'(bus.sender_in_reset), 1);
    rx_auto  = 1'b1;
    rx_force = 1'b0;
    done     = 1'b0;
    saw_rst  = 1'b1;
    saw_drop = 1'b0;
    dval     = 'h62;
    for (int c = 0; c < 30 && !done; c++) begin
      bus.push_data = DW'(dval);
      dval++;
      #1;
      if (bus.push_ready) done = 1'b1;
      else begin
        if (saw_rst && !bus.sender_in_reset) saw_drop = 1'b1;
        tick();
        chk($sformatf("mid_no_out_valid_c%0d", c), 32'(bus.out_valid), 0);
      end
    end
    chk("mid_active_again",  done ? 1 : 0, 1);
    chk("mid_rst_wait_seen", saw_drop ? 1 : 0, 1);
    chk("mid_count_reload",  32'(cnt), 9);
    chk("mid_avail_reload",  32'(avail), 9);
    tick();
    chk("mid_resume_out_valid", 32'(bus.out_valid), 1);
    chk("mid_resume_count",     32'(cnt), 8);

    // ---- overflow ----
    bus.push_valid    = 1'b0;
    bus.credit_return = 1'b1;
    repeat (9) tick();
    chk("ovf_count_full", 32'(cnt), 17);
    chk("ovf_no_error_yet", 32'(err), 0);
    tick();
    chk("ovf_count_saturated", 32'(cnt), 17);
`ifdef CREDIT_SENDER_ERR_CHECK_EN
    chk("ovf_error_set", 32'(err), 1);
`else
    chk("ovf_error_tied", 32'(err), 0);
`endif
    bus.credit_return = 1'b0;
    repeat (2) tick();
`ifdef CREDIT_SENDER_ERR_CHECK_EN
    chk("ovf_error_sticky", 32'(err), 1);
`else
    chk("ovf_error_still_0", 32'(err), 0);
`endif
    chk("ovf_count_hold", 32'(cnt), 17);
    rst_n = 1'b0;
    #1;
    chk("ovf_error_cleared", 32'(err), 0);
    chk("ovf_count_cleared", 32'(cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
